// File: rtl/cache_pkg.sv
// Shared cache definitions used by the tag RAM, the tag matcher and the controller.
package cache_pkg;

  localparam int unsigned TAG_W_DEFAULT = 3;
  localparam int unsigned WAYS_DEFAULT  = 4;
  localparam int unsigned WAY_W_DEFAULT = $clog2(WAYS_DEFAULT);

  typedef logic [TAG_W_DEFAULT-1:0] tag_t;

endpackage

// File: rtl/way_priority_enc.sv
// Combinational way encoder: lowest set index, any-set and more-than-one-set flags.
module way_priority_enc #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned WAY_W = 2
) (
  input  logic [WAYS-1:0]  vec_i,
  output logic [WAY_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so the lowest set bit is the last to write idx_o.
  always_comb begin
    idx_o = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = WAY_W'(i);
      end
    end
    any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_o = |(vec_i & (vec_i - WAYS'(1)));
  end

endmodule

// File: rtl/tag_match_pipe.sv
// Two-stage tag matcher: S1 captures the set read, S2 holds the registered compare result.
module tag_match_pipe
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEFAULT,
  parameter int unsigned WAYS  = WAYS_DEFAULT,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic [WAYS-1:0]       way_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic [WAYS-1:0]       rsp_hit_vec,
  output logic                  rsp_multi_hit,
  input  logic                  stat_clear,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic                  s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
  logic [WAYS*TAG_W-1:0] s1_tags_q, s1_tags_d;
  logic [WAYS-1:0]       s1_wvalid_q, s1_wvalid_d;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_hit_q, s2_hit_d;
  logic [WAY_W-1:0]      s2_way_q, s2_way_d;
  logic [WAYS-1:0]       s2_vec_q, s2_vec_d;
  logic                  s2_multi_q, s2_multi_d;

  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic                  rsp_fire, s1_advance, req_fire;
  logic [WAYS-1:0]       hit_vec;
  logic [WAY_W-1:0]      enc_way;
  logic                  enc_any, enc_multi;

  assign rsp_fire   = s2_valid_q & rsp_ready;
  assign s1_advance = ~s2_valid_q | rsp_fire;
  assign req_ready  = ~s1_valid_q | s1_advance;
  assign req_fire   = req_valid & req_ready;

  // Per-way compare on the captured set; invalid ways are masked out.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i] = s1_wvalid_q[i] && (s1_tags_q[i*TAG_W +: TAG_W] == s1_tag_q);
    end
  end

  way_priority_enc #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_enc (
    .vec_i   (hit_vec),
    .idx_o   (enc_way),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  // Stage next-state: each stage refills only when it is empty or draining this cycle.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_tag_d    = s1_tag_q;
    s1_tags_d   = s1_tags_q;
    s1_wvalid_d = s1_wvalid_q;
    if (req_ready) begin
      s1_valid_d = req_valid;
    end
    if (req_fire) begin
      s1_tag_d    = req_tag;
      s1_tags_d   = way_tags;
      s1_wvalid_d = way_valid;
    end

    s2_valid_d = s2_valid_q;
    s2_hit_d   = s2_hit_q;
    s2_way_d   = s2_way_q;
    s2_vec_d   = s2_vec_q;
    s2_multi_d = s2_multi_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_d   = enc_any;
        s2_way_d   = enc_way;
        s2_vec_d   = hit_vec;
        s2_multi_d = enc_multi;
      end
    end
  end

  // Saturating statistics; a clear wins over a coincident increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stat_clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (rsp_fire) begin
      if (s2_hit_q) begin
        if (hit_cnt_q != CntMax) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != CntMax) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_tags_q   <= '0;
      s1_wvalid_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_way_q    <= '0;
      s2_vec_q    <= '0;
      s2_multi_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_tags_q   <= s1_tags_d;
      s1_wvalid_q <= s1_wvalid_d;
      s2_valid_q  <= s2_valid_d;
      s2_hit_q    <= s2_hit_d;
      s2_way_q    <= s2_way_d;
      s2_vec_q    <= s2_vec_d;
      s2_multi_q  <= s2_multi_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign rsp_valid     = s2_valid_q;
  assign rsp_hit       = s2_hit_q;
  assign rsp_way       = s2_way_q;
  assign rsp_hit_vec   = s2_vec_q;
  assign rsp_multi_hit = s2_multi_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_tag_match_pipe.sv
// Scoreboard bench for tag_match_pipe: directed vectors, monitor compares on each handshake.
module tb_tag_match_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_tag;
  logic [11:0] way_tags;
  logic [3:0]  way_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic [3:0]  rsp_hit_vec;
  logic        rsp_multi_hit;
  logic        stat_clear;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  // Second instance with 2-bit counters, fed identically, for saturation.
  logic        s_req_ready, s_rsp_valid, s_rsp_hit, s_rsp_multi_hit;
  logic [1:0]  s_rsp_way;
  logic [3:0]  s_rsp_hit_vec;
  logic [1:0]  s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  tag_match_pipe #(.TAG_W(3), .WAYS(4), .CNT_W(16)) dut (
    .clk (clk), .rst_n (rst_n), .req_valid (req_valid), .req_ready (req_ready),
    .req_tag (req_tag), .way_tags (way_tags), .way_valid (way_valid),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_hit (rsp_hit), .rsp_way (rsp_way),
    .rsp_hit_vec (rsp_hit_vec), .rsp_multi_hit (rsp_multi_hit), .stat_clear (stat_clear),
    .hit_count (hit_count), .miss_count (miss_count)
  );

  tag_match_pipe #(.TAG_W(3), .WAYS(4), .CNT_W(2)) dut_small (
    .clk (clk), .rst_n (rst_n), .req_valid (req_valid), .req_ready (s_req_ready),
    .req_tag (req_tag), .way_tags (way_tags), .way_valid (way_valid),
    .rsp_valid (s_rsp_valid), .rsp_ready (rsp_ready), .rsp_hit (s_rsp_hit),
    .rsp_way (s_rsp_way), .rsp_hit_vec (s_rsp_hit_vec), .rsp_multi_hit (s_rsp_multi_hit),
    .stat_clear (stat_clear), .hit_count (s_hit_count), .miss_count (s_miss_count)
  );

  typedef struct {
    logic [2:0]  tag;
    logic [11:0] tags;
    logic [3:0]  vld;
    logic        hit;
    logic [1:0]  way;
    logic [3:0]  vec;
    logic        multi;
  } vec_t;

  vec_t vecs [10];
  vec_t exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one vector and hold it until accepted; expected result is queued on accept.
  task automatic send(input int idx);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_tag   = vecs[idx].tag;
    way_tags  = vecs[idx].tags;
    way_valid = vecs[idx].vld;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(vecs[idx]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops on every response handshake, tracks counters, checks hold under stall.
  logic [31:0] m_hit, m_miss, m_shit, m_smiss;
  logic        stall_prev;
  logic        h_hit, h_multi;
  logic [1:0]  h_way;
  logic [3:0]  h_vec;

  always @(negedge clk) begin : monitor
    vec_t e;
    logic hs, hs_hit;
    hs = 1'b0;
    hs_hit = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_hit = 0; m_miss = 0; m_shit = 0; m_smiss = 0;
      stall_prev = 1'b0;
    end else begin
      chk("hit_count", 32'(hit_count), m_hit);
      chk("miss_count", 32'(miss_count), m_miss);
      chk("small_hit_count", 32'(s_hit_count), m_shit);
      chk("small_miss_count", 32'(s_miss_count), m_smiss);
      if (stall_prev) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_hit", 32'(rsp_hit), 32'(h_hit));
        chk("hold_way", 32'(rsp_way), 32'(h_way));
        chk("hold_vec", 32'(rsp_hit_vec), 32'(h_vec));
        chk("hold_multi", 32'(rsp_multi_hit), 32'(h_multi));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          n_rsp++;
          chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
          chk("rsp_way", 32'(rsp_way), 32'(e.way));
          chk("rsp_hit_vec", 32'(rsp_hit_vec), 32'(e.vec));
          chk("rsp_multi_hit", 32'(rsp_multi_hit), 32'(e.multi));
          hs = 1'b1;
          hs_hit = e.hit;
        end
      end
      if (stat_clear) begin
        m_hit = 0; m_miss = 0; m_shit = 0; m_smiss = 0;
      end else if (hs) begin
        if (hs_hit) begin
          if (m_hit != 32'd65535) m_hit++;
          if (m_shit != 32'd3) m_shit++;
        end else begin
          if (m_miss != 32'd65535) m_miss++;
          if (m_smiss != 32'd3) m_smiss++;
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      h_hit   = rsp_hit;
      h_way   = rsp_way;
      h_vec   = rsp_hit_vec;
      h_multi = rsp_multi_hit;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // tags written {way3, way2, way1, way0}
    vecs[0] = '{3'd7, {3'd5, 3'd2, 3'd7, 3'd1}, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0};
    vecs[1] = '{3'd7, {3'd5, 3'd2, 3'd7, 3'd1}, 4'b1101, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[2] = '{3'd4, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b1010, 1'b1, 2'd1, 4'b1010, 1'b1};
    vecs[3] = '{3'd1, {3'd5, 3'd2, 3'd7, 3'd1}, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0};
    vecs[4] = '{3'd5, {3'd5, 3'd2, 3'd7, 3'd1}, 4'b1111, 1'b1, 2'd3, 4'b1000, 1'b0};
    vecs[5] = '{3'd3, {3'd5, 3'd2, 3'd7, 3'd1}, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[6] = '{3'd6, {3'd6, 3'd6, 3'd0, 3'd6}, 4'b1111, 1'b1, 2'd0, 4'b1101, 1'b1};
    vecs[7] = '{3'd3, {3'd3, 3'd3, 3'd3, 3'd3}, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0};
    vecs[8] = '{3'd2, {3'd2, 3'd2, 3'd1, 3'd0}, 4'b1100, 1'b1, 2'd2, 4'b1100, 1'b1};
    vecs[9] = '{3'd7, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; way_tags = '0; way_valid = '0;
    rsp_ready = 1'b1; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("reset_rsp_way", 32'(rsp_way), 32'd0);
    chk("reset_rsp_vec", 32'(rsp_hit_vec), 32'd0);
    chk("reset_rsp_multi", 32'(rsp_multi_hit), 32'd0);
    chk("reset_hit_count", 32'(hit_count), 32'd0);
    chk("reset_miss_count", 32'(miss_count), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single hit with latency check, then masking and multi-hit.
    send(0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    send(1);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(2);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("after3_hit_count", 32'(hit_count), 32'd2);
    chk("after3_miss_count", 32'(miss_count), 32'd1);

    // Backpressure: five back-to-back requests, consumer stalled for four cycles.
    fork
      begin
        for (int i = 3; i <= 7; i++) send(i);
        req_valid = 1'b0;
      end
      begin
        logic exp_rdy [4];
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("bp_req_ready", 32'(req_ready), 32'(exp_rdy[c]));
          @(posedge clk);
          #1;
        end
        rsp_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_total_count", 32'(hit_count) + 32'(miss_count), 32'd8);
    chk("bp_hit_count", 32'(hit_count), 32'd5);
    chk("sat_small_hit", 32'(s_hit_count), 32'd3);
    chk("sat_small_miss", 32'(s_miss_count), 32'd3);

    // Clear coincident with a hit handshake wins.
    send(8);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_align_valid", 32'(rsp_valid), 32'd1);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    chk("clr_hit_count", 32'(hit_count), 32'd0);
    chk("clr_miss_count", 32'(miss_count), 32'd0);
    chk("clr_small_hit", 32'(s_hit_count), 32'd0);
    send(9);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_clr_miss", 32'(miss_count), 32'd1);
    chk("post_clr_hit", 32'(hit_count), 32'd0);

    // Async reset with both stages full.
    rsp_ready = 1'b0;
    send(3);
    send(4);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_hit_count", 32'(hit_count), 32'd0);
    chk("arst_miss_count", 32'(miss_count), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(5);
    req_valid = 1'b0;
    @(negedge clk);
    chk("arst_latency1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("arst_latency2", 32'(rsp_valid), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("arst_miss_after", 32'(miss_count), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("response_total", 32'(n_rsp), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
